rotator_arb_seq: RTL and testbench
==================================

Name: rotator_arb_seq

Overview:
Sequencing controller that shares one right-rotate datapath between two requesters. The rotator is 2**N bits wide and rotates right by a log-stage amount. The block arbitrates round-robin between the requesters and accepts one operand per transaction over a valid/ready handshake. It applies the rotation one binary stage per clock (stage i rotates by 2**i when amt[i]=1) and returns the result with the winning requester's ID over a valid/ready output port. It sits between request sources (e.g. switch/button front-ends) and result consumers (e.g. display logic).

Parameters:
N, 3, log2 of data width; data width W = 2**N, shift amount width N, stage count N.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operand
req0_ready  output  1  requester 0 handshake accepted this cycle
req0_data  input  W  requester 0 operand
req0_amt  input  N  requester 0 right-rotate amount
req1_valid  input  1  requester 1 has an operand
req1_ready  output  1  requester 1 handshake accepted this cycle
req1_data  input  W  requester 1 operand
req1_amt  input  N  requester 1 right-rotate amount
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_data  output  W  rotated result
out_src  output  1  ID of requester that issued the result
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (sync, active-high): state=IDLE, out_valid=0, out_data=0, out_src=0, busy=0, stage counter=0, last_grant=1 (req0 wins the first tie). req0_ready and req1_ready are 0 during any cycle where reset=1.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, grant (combinational):
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: no grant.
  - reqX_ready = (state==IDLE) and grant==X. At most one ready is high in any cycle.
- Acceptance (edge E0): reqX_valid and reqX_ready.
  - Capture data into the work register, amt into the amt register, and X into the src register.
  - Set last_grant=X, stage=0, go to SHIFT.
- SHIFT: on each edge, if amt_reg[stage]=1, rotate work right by 2**stage (bit 0 wraps to the MSB), otherwise hold; then stage++.
  - After stage N-1 is applied (edge E0+N), load out_data=work and out_src=src_reg, set out_valid=1, go to DONE.
  - Every transaction takes exactly N SHIFT cycles, including amt=0; there is no early exit.
  - Result equals a rotated right by amt mod W.
- DONE: out_valid=1; out_data and out_src are held stable until a handshake.
  - out_valid and out_ready on an edge: out_valid=0, go to IDLE.
  - No request is accepted in the same cycle as the output handshake.
  - Throughput: one transaction per N+2 cycles with out_ready tied high.
- Latency: out_valid is first high in the cycle following edge E0+N, i.e. N cycles after the acceptance edge.
- Requesters may drop valid without a handshake; this has no effect on state or last_grant. Inputs are sampled only on the acceptance edge; later changes are ignored.
- busy = (state != IDLE).
- Reset mid-operation (SHIFT or DONE): the transaction is discarded, no output handshake occurs, and all registers return to reset values on that edge.
- Stage counter width is ceil(log2(N)), minimum 1 bit; no wrap beyond N-1.

Test Plan:
1. N=3; req0 data=0x96, amt=3, out_ready=1 -> req0_ready high 1 cycle; out_valid exactly 3 cycles after acceptance; out_data=0xD2, out_src=0; busy high from acceptance until the output handshake.
2. req1 data=0x01, amt=7 -> out_data=0x02, out_src=1. req1 data=0x96, amt=0 -> out_data=0x96 after 3 SHIFT cycles, no early exit.
3. Both valid continuously from reset, each with a distinct operand -> grants alternate 0,1,0,1; out_src sequence 0,1,0,1; never both ready in one cycle; N+2 cycles per transaction.
4. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid=1 and out_data/out_src stable; req0_ready=req1_ready=0; release -> single output handshake, IDLE next cycle.
5. Reset asserted during the 2nd SHIFT cycle -> next cycle state=IDLE, out_valid=0, out_data=0, last_grant=1; the aborted result never appears; with both requesters valid, req0 is granted next.
6. req0_valid pulses for 1 cycle while busy, then drops -> no acceptance, no output, last_grant unchanged.

Source files
------------

// File: rtl/rotator_arb_seq_if.sv
// Request/result bundle for rotator_arb_seq: two operand requesters and one
// result port, each a valid/ready handshake.
interface rotator_arb_seq_if #(parameter int N = 3);
   localparam int W = 2**N;

   logic         req0_valid;
   logic         req0_ready;
   logic [W-1:0] req0_data;
   logic [N-1:0] req0_amt;
   logic         req1_valid;
   logic         req1_ready;
   logic [W-1:0] req1_data;
   logic [N-1:0] req1_amt;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_src;

   modport slave (
      input  req0_valid, req0_data, req0_amt,
      output req0_ready,
      input  req1_valid, req1_data, req1_amt,
      output req1_ready,
      output out_valid, out_data, out_src,
      input  out_ready
   );

   modport master (
      output req0_valid, req0_data, req0_amt,
      input  req0_ready,
      output req1_valid, req1_data, req1_amt,
      input  req1_ready,
      input  out_valid, out_data, out_src,
      output out_ready
   );
endinterface

// File: rtl/rotator_arb_seq.sv
// Round-robin two-requester front end for a shared right rotator that applies
// one binary rotate stage per clock (N stages, fixed latency).
module rotator_arb_seq #(
   parameter int N = 3
) (
   input  logic             clk,
   input  logic             reset,
   rotator_arb_seq_if.slave bus,
   output logic             busy
);
   localparam int W  = 2**N;
   localparam int SW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t              state, state_nxt;
   logic [W-1:0]        work, work_nxt, out_data_r;
   logic [N-1:0]        amt_reg;
   logic [SW-1:0]       stage;
   logic                src_reg, last_grant, out_src_r, out_valid_r;
   logic                grant_vld, grant, accept, last_stage;
   logic [N-1:0][W-1:0] rot_opt;

   // rot_opt[i] is work rotated right by 2**i; stage selects which one applies
   for (genvar i = 0; i < N; i++) begin : g_rot
      assign rot_opt[i] = {work[(2**i)-1:0], work[W-1:2**i]};
   end

   always_comb begin
      grant_vld = bus.req0_valid | bus.req1_valid;
      grant     = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
   end

   assign accept         = !reset && (state == IDLE) && grant_vld;
   assign bus.req0_ready = accept && !grant;
   assign bus.req1_ready = accept && grant;
   assign last_stage     = (stage == SW'(N-1));
   assign work_nxt       = amt_reg[stage] ? rot_opt[stage] : work;
   assign busy           = (state != IDLE);
   assign bus.out_valid  = out_valid_r;
   assign bus.out_data   = out_data_r;
   assign bus.out_src    = out_src_r;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)        state_nxt = SHIFT;
         SHIFT:   if (last_stage)    state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         work        <= '0;
         amt_reg     <= '0;
         src_reg     <= 1'b0;
         stage       <= '0;
         last_grant  <= 1'b1;
         out_data_r  <= '0;
         out_src_r   <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (accept) begin
               work       <= grant ? bus.req1_data : bus.req0_data;
               amt_reg    <= grant ? bus.req1_amt  : bus.req0_amt;
               src_reg    <= grant;
               last_grant <= grant;
               stage      <= '0;
            end
            SHIFT: begin
               work <= work_nxt;
               if (last_stage) begin
                  stage       <= '0;
                  out_data_r  <= work_nxt;
                  out_src_r   <= src_reg;
                  out_valid_r <= 1'b1;
               end else begin
                  stage <= stage + SW'(1);
               end
            end
            DONE: if (bus.out_ready) out_valid_r <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_rotator_arb_seq.sv
// Directed bench for rotator_arb_seq (N=3): latency, arbitration order,
// backpressure, mid-operation reset and requests dropped while busy.
module tb_rotator_arb_seq;
   logic clk = 1'b0;
   logic reset;
   logic busy;
   int   checks   = 0;
   int   failures = 0;

   rotator_arb_seq_if #(.N(3)) bus();

   rotator_arb_seq #(.N(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req0(input logic v, input logic [7:0] d, input logic [2:0] a);
      bus.req0_valid = v; bus.req0_data = d; bus.req0_amt = a;
   endtask

   task automatic set_req1(input logic v, input logic [7:0] d, input logic [2:0] a);
      bus.req1_valid = v; bus.req1_data = d; bus.req1_amt = a;
   endtask

   initial begin
      reset = 1'b1;
      bus.out_ready = 1'b1;
      set_req0(1'b1, 8'h55, 3'd1);
      set_req1(1'b0, 8'h00, 3'd0);
      step(); step();
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_out_data",  bus.out_data,  8'h00);
      chk("rst_out_src",   bus.out_src,   1'b0);
      chk("rst_busy",      busy,          1'b0);
      chk("rst_ready0",    bus.req0_ready, 1'b0);
      chk("rst_ready1",    bus.req1_ready, 1'b0);

      // T1: req0 0x96 ror 3 -> 0xD2
      reset = 1'b0;
      set_req0(1'b1, 8'h96, 3'd3);
      #1;
      chk("t1_ready0", bus.req0_ready, 1'b1);
      chk("t1_ready1", bus.req1_ready, 1'b0);
      step();
      set_req0(1'b0, 8'h00, 3'd0);
      #1;
      chk("t1_ready0_after", bus.req0_ready, 1'b0);
      chk("t1_busy_s0",  busy, 1'b1);
      chk("t1_valid_s0", bus.out_valid, 1'b0);
      step();
      chk("t1_valid_s1", bus.out_valid, 1'b0);
      step();
      chk("t1_valid_s2", bus.out_valid, 1'b0);
      chk("t1_busy_s2",  busy, 1'b1);
      step();
      chk("t1_valid", bus.out_valid, 1'b1);
      chk("t1_data",  bus.out_data,  8'hD2);
      chk("t1_src",   bus.out_src,   1'b0);
      chk("t1_busy_done", busy, 1'b1);
      step();
      chk("t1_valid_clr", bus.out_valid, 1'b0);
      chk("t1_busy_idle", busy, 1'b0);

      // T2a: req1 0x01 ror 7 -> 0x02
      set_req1(1'b1, 8'h01, 3'd7);
      #1;
      chk("t2a_ready1", bus.req1_ready, 1'b1);
      chk("t2a_ready0", bus.req0_ready, 1'b0);
      step();
      set_req1(1'b0, 8'h00, 3'd0);
      step(); step(); step();
      chk("t2a_valid", bus.out_valid, 1'b1);
      chk("t2a_data",  bus.out_data,  8'h02);
      chk("t2a_src",   bus.out_src,   1'b1);
      step();

      // T2b: amt=0 still takes the full stage count
      set_req1(1'b1, 8'h96, 3'd0);
      step();
      set_req1(1'b0, 8'h00, 3'd0);
      step(); step();
      chk("t2b_valid_early", bus.out_valid, 1'b0);
      step();
      chk("t2b_valid", bus.out_valid, 1'b1);
      chk("t2b_data",  bus.out_data,  8'h96);
      chk("t2b_src",   bus.out_src,   1'b1);
      step();

      // T3: both valid from reset -> alternating grants, 5 cycles each
      reset = 1'b1;
      step();
      reset = 1'b0;
      set_req0(1'b1, 8'h11, 3'd1);
      set_req1(1'b1, 8'h80, 3'd1);
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t3_ready0", bus.req0_ready, (k % 2) == 0);
         chk("t3_ready1", bus.req1_ready, (k % 2) == 1);
         step();
         chk("t3_no_ready0", bus.req0_ready, 1'b0);
         chk("t3_no_ready1", bus.req1_ready, 1'b0);
         step(); step();
         chk("t3_valid_early", bus.out_valid, 1'b0);
         step();
         chk("t3_valid", bus.out_valid, 1'b1);
         chk("t3_src",   bus.out_src,   (k % 2) == 1);
         chk("t3_data",  bus.out_data,  ((k % 2) == 0) ? 8'h88 : 8'h40);
         step();
      end
      set_req0(1'b0, 8'h00, 3'd0);
      set_req1(1'b0, 8'h00, 3'd0);

      // T4: backpressure in DONE, 0x3C ror 2 -> 0x0F
      bus.out_ready = 1'b0;
      set_req0(1'b1, 8'h3C, 3'd2);
      step();
      set_req0(1'b0, 8'h00, 3'd0);
      step(); step(); step();
      chk("t4_valid", bus.out_valid, 1'b1);
      set_req0(1'b1, 8'hAA, 3'd1);
      set_req1(1'b1, 8'h55, 3'd1);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t4_hold_valid", bus.out_valid, 1'b1);
         chk("t4_hold_data",  bus.out_data,  8'h0F);
         chk("t4_hold_src",   bus.out_src,   1'b0);
         chk("t4_ready0",     bus.req0_ready, 1'b0);
         chk("t4_ready1",     bus.req1_ready, 1'b0);
      end
      set_req0(1'b0, 8'h00, 3'd0);
      set_req1(1'b0, 8'h00, 3'd0);
      bus.out_ready = 1'b1;
      step();
      chk("t4_release_valid", bus.out_valid, 1'b0);
      chk("t4_release_busy",  busy, 1'b0);
      step();
      chk("t4_single_hs", bus.out_valid, 1'b0);

      // T5: reset during second SHIFT cycle; last_grant=0 before abort
      set_req0(1'b1, 8'h96, 3'd3);
      step();
      set_req0(1'b0, 8'h00, 3'd0);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t5_valid", bus.out_valid, 1'b0);
      chk("t5_data",  bus.out_data,  8'h00);
      chk("t5_src",   bus.out_src,   1'b0);
      chk("t5_busy",  busy, 1'b0);
      set_req0(1'b1, 8'h01, 3'd0);
      set_req1(1'b1, 8'h02, 3'd0);
      #1;
      chk("t5_ready0", bus.req0_ready, 1'b1);
      chk("t5_ready1", bus.req1_ready, 1'b0);
      set_req0(1'b0, 8'h00, 3'd0);
      set_req1(1'b0, 8'h00, 3'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("t5_no_result", bus.out_valid, 1'b0);
      end

      // T6: req0 pulse while busy is ignored; 0x01 ror 1 -> 0x80
      set_req1(1'b1, 8'h01, 3'd1);
      step();
      set_req1(1'b0, 8'h00, 3'd0);
      set_req0(1'b1, 8'hFF, 3'd4);
      #1;
      chk("t6_pulse_ready0", bus.req0_ready, 1'b0);
      step();
      set_req0(1'b0, 8'h00, 3'd0);
      step(); step();
      chk("t6_valid", bus.out_valid, 1'b1);
      chk("t6_data",  bus.out_data,  8'h80);
      chk("t6_src",   bus.out_src,   1'b1);
      step();
      step();
      chk("t6_no_extra", bus.out_valid, 1'b0);
      chk("t6_idle",     busy, 1'b0);
      set_req0(1'b1, 8'h00, 3'd0);
      set_req1(1'b1, 8'h00, 3'd0);
      #1;
      chk("t6_ready0", bus.req0_ready, 1'b1);
      chk("t6_ready1", bus.req1_ready, 1'b0);
      set_req0(1'b0, 8'h00, 3'd0);
      set_req1(1'b0, 8'h00, 3'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
